// File: rtl/wb_reg_bank.sv
// Wishbone slave register bank: NUM_REGS read/write control registers,
// an interrupt-enable register, a sticky W1C interrupt-status register fed
// by rising edges of user events, and a read-only status word.
module wb_reg_bank #(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 4,
  parameter int          NUM_EVENTS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wbs_we_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]          wbs_dat_i,
  output logic [DATA_WIDTH-1:0]          wbs_dat_o,
  output logic                           wbs_ack_o,
  output logic                           wbs_int_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_EVENTS-1:0]          event_i,
  input  logic [DATA_WIDTH-1:0]          status_i
);

  localparam logic [31:0] OFF_INT_EN   = 32'(NUM_REGS);
  localparam logic [31:0] OFF_INT_STAT = 32'(NUM_REGS + 1);
  localparam logic [31:0] OFF_STATUS   = 32'(NUM_REGS + 2);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   ctrl_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   ctrl_d [NUM_REGS];
  logic [NUM_EVENTS-1:0]   int_en_q, int_en_d;
  logic [NUM_EVENTS-1:0]   int_stat_q, int_stat_d;
  logic [NUM_EVENTS-1:0]   event_d_q;
  logic [NUM_EVENTS-1:0]   rise, w1c;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    int_q, int_d;
  logic [31:0]             offset;
  logic                    access;
  logic [DATA_WIDTH-1:0]   rd_data;

  // Address decode and read-data multiplexer (unmapped offsets read 0).
  always_comb begin
    offset  = wbs_adr_i - BASE_ADDR;
    access  = (state_q == S_IDLE) && wbs_stb_i && wbs_cyc_i;
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (offset == k) rd_data = ctrl_q[k];
    end
    if (offset == OFF_INT_EN)   rd_data[NUM_EVENTS-1:0] = int_en_q;
    if (offset == OFF_INT_STAT) rd_data[NUM_EVENTS-1:0] = int_stat_q;
    if (offset == OFF_STATUS)   rd_data = status_i;
  end

  // Handshake FSM next state plus register side effects and event capture.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    dat_d    = dat_q;
    int_en_d = int_en_q;
    w1c      = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_d[k] = ctrl_q[k];

    case (state_q)
      S_IDLE: begin
        if (access) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (wbs_we_i) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
              if (offset == k) ctrl_d[k] = wbs_dat_i;
            end
            if (offset == OFF_INT_EN)   int_en_d = wbs_dat_i[NUM_EVENTS-1:0];
            if (offset == OFF_INT_STAT) w1c      = wbs_dat_i[NUM_EVENTS-1:0];
          end else begin
            dat_d = rd_data;
          end
        end
      end
      S_ACK: begin
        // Dropping either stb or cyc ends the handshake; the side effect already happened.
        if (!(wbs_stb_i && wbs_cyc_i)) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
      end
    endcase

    // Set wins over a coincident W1C of the same bit.
    rise       = event_i & ~event_d_q;
    int_stat_d = (int_stat_q & ~w1c) | rise;
    int_d      = |(int_stat_q & int_en_q);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      int_q      <= 1'b0;
      int_en_q   <= '0;
      int_stat_q <= '0;
      event_d_q  <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      int_q      <= int_d;
      int_en_q   <= int_en_d;
      int_stat_q <= int_stat_d;
      event_d_q  <= event_i;
      for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_q[k] <= ctrl_d[k];
    end
  end

  // Flatten control registers onto the user-core export bus.
  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_int_o = int_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Scoreboard bench for wb_reg_bank: stimulus pushes expected responses,
// a negedge monitor pops them on each rising ack.
module tb_wb_reg_bank;
  localparam int          DW   = 32;
  localparam int          NR   = 4;
  localparam int          NE   = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0]        adr = '0;
  logic [DW-1:0]      dat_i = '0, status = '0;
  logic [NE-1:0]      ev = '0;
  logic [DW-1:0]      dat_o;
  logic               ack, irq;
  logic [NR*DW-1:0]   regs;

  always #5 clk = ~clk;

  wb_reg_bank #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .NUM_EVENTS(NE),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wbs_we_i (we),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o),
    .wbs_ack_o(ack),
    .wbs_int_o(irq),
    .regs_o   (regs),
    .event_i  (ev),
    .status_i (status)
  );

  typedef struct {
    bit               is_rd;
    logic [DW-1:0]    rdata;
    logic [NR*DW-1:0] regs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: register contents plus bus-busy flag.
  logic [DW-1:0] m_ctrl [NR];
  logic [NE-1:0] m_en = '0, m_stat = '0, m_prev = '0;
  bit            m_busy = 0;

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = m_ctrl[k];
    return f;
  endfunction

  task automatic check(input string name, input logic [NR*DW-1:0] act,
                       input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: update model for this edge, push expectation, check irq.
  task automatic cycle();
    bit            acc, exp_int;
    logic [NE-1:0] rise, w1c;
    logic [31:0]   off;
    exp_t          e;
    off     = adr - BASE;
    acc     = !rst && stb && cyc && !m_busy;
    exp_int = !rst && (|(m_stat & m_en));
    if (rst) begin
      for (int k = 0; k < NR; k++) m_ctrl[k] = '0;
      m_en = '0; m_stat = '0; m_prev = '0; m_busy = 0;
    end else begin
      rise = ev & ~m_prev;
      w1c  = '0;
      if (acc) begin
        e.is_rd = !we;
        e.rdata = '0;
        if (!we) begin
          if (off < NR)            e.rdata = m_ctrl[off];
          else if (off == NR)      e.rdata = DW'(m_en);
          else if (off == NR + 1)  e.rdata = DW'(m_stat);
          else if (off == NR + 2)  e.rdata = status;
        end else begin
          if (off < NR)            m_ctrl[off] = dat_i;
          else if (off == NR)      m_en = dat_i[NE-1:0];
          else if (off == NR + 1)  w1c = dat_i[NE-1:0];
        end
        m_busy = 1;
      end else if (m_busy && !(stb && cyc)) begin
        m_busy = 0;
      end
      m_stat = (m_stat & ~w1c) | rise;
      m_prev = ev;
      if (acc) begin
        e.regs = m_flat();
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("irq", NR*DW'(irq), NR*DW'(exp_int));
  endtask

  task automatic idle(input int n, input logic [NE-1:0] e);
    ev = e;
    repeat (n) cycle();
  endtask

  // Full bus transaction; event lines change on the access edge.
  task automatic xfer(input bit w, input logic [31:0] off, input logic [DW-1:0] d,
                      input logic [NE-1:0] e, input logic [DW-1:0] st,
                      input int hold, input bit drop_cyc);
    adr = BASE + off; we = w; dat_i = d; ev = e; status = st;
    stb = 1'b1; cyc = 1'b1;
    cycle();
    status = $urandom;
    repeat (hold) cycle();
    if (drop_cyc) cyc = 1'b0; else stb = 1'b0;
    cycle();
    check("ack_drop", NR*DW'(ack), '0);
    stb = 1'b0; cyc = 1'b0;
  endtask

  // Monitor: compare on each rising ack, and check read data holds while acked.
  logic          ack_prev = 1'b0;
  logic [DW-1:0] held = '0;
  exp_t          mon_e;
  always @(negedge clk) begin
    if (ack === 1'b1 && ack_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_ack actual=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) check("rdata", NR*DW'(dat_o), NR*DW'(mon_e.rdata));
        check("regs", regs, mon_e.regs);
      end
      held = dat_o;
    end else if (ack === 1'b1) begin
      check("dat_hold", NR*DW'(dat_o), NR*DW'(held));
    end
    ack_prev = ack;
  end

  initial begin
    for (int k = 0; k < NR; k++) m_ctrl[k] = '0;
    rst = 1'b1;
    repeat (2) cycle();
    check("rst_ack",  NR*DW'(ack),   '0);
    check("rst_dat",  NR*DW'(dat_o), '0);
    check("rst_regs", regs,          '0);
    rst = 1'b0;
    cycle();

    // Control register write/read
    xfer(1, 2, 32'hDEADBEEF, '0, '0, 1, 0);
    xfer(0, 2, '0, '0, '0, 0, 0);
    xfer(0, 0, '0, '0, '0, 0, 0);
    // STATUS is read-only
    xfer(0, 6, '0, '0, 32'h12345678, 0, 0);
    xfer(1, 6, 32'hFFFFFFFF, '0, 32'h12345678, 0, 0);
    xfer(0, 6, '0, '0, 32'h12345678, 0, 0);
    // Interrupt enable, event capture, W1C
    xfer(1, 4, 32'hFFFF_FFF5, '0, '0, 0, 0);
    xfer(0, 4, '0, '0, '0, 0, 0);
    idle(1, 4'b0011);
    idle(3, 4'b0000);
    xfer(0, 5, '0, '0, '0, 0, 0);
    xfer(1, 5, 32'h1, '0, '0, 0, 0);
    idle(2, 4'b0000);
    xfer(0, 5, '0, '0, '0, 0, 0);
    // Rising edge coincident with W1C: set wins; held level does not re-set
    xfer(1, 5, 32'h4, 4'b0100, '0, 0, 0);
    xfer(0, 5, '0, 4'b0100, '0, 0, 0);
    xfer(1, 5, 32'h4, 4'b0100, '0, 0, 0);
    idle(2, 4'b0100);
    xfer(0, 5, '0, 4'b0100, '0, 0, 0);
    idle(1, 4'b0000);
    // Unmapped offset
    xfer(0, 9, '0, '0, '0, 0, 0);
    xfer(1, 9, 32'hAAAA5555, '0, '0, 2, 1);
    xfer(0, 9, '0, '0, '0, 0, 0);
    xfer(0, 1, '0, '0, '0, 0, 0);
    // Reset in the middle of a handshake with stb held
    xfer(1, 4, 32'hF, '0, '0, 0, 0);
    idle(2, '0);
    adr = BASE + 1; we = 1'b1; dat_i = 32'h77; stb = 1'b1; cyc = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_ack",  NR*DW'(ack), '0);
    check("midrst_regs", regs,        '0);
    rst = 1'b0;
    cycle();
    cycle();
    stb = 1'b0;
    cycle();
    check("midrst_ack_drop", NR*DW'(ack), '0);
    cyc = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 9));
      xfer($urandom_range(0, 1), off, $urandom, NE'($urandom), $urandom,
           $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), NE'($urandom));
    end

    idle(3, '0);
    check("sb_empty", NR*DW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_bank.md
Name: wb_reg_bank

Overview:
Parametrised Wishbone slave register bank and the successor to the fixed three-address slave stub. It provides NUM_REGS read/write control registers that are exported to the user core. It also provides an interrupt-enable register, a sticky interrupt-status register (write-1-to-clear, edge-triggered from user events) and a read-only status word. It sits on the Wishbone interconnect as a DRT-enumerated slave in front of a user core.

Parameters:
DATA_WIDTH, 32, bus and register width in bits (8..32).
NUM_REGS, 4, number of read/write control registers (1..16).
NUM_EVENTS, 4, number of interrupt event inputs (1..DATA_WIDTH).
BASE_ADDR, 32'h00000000, address of register offset 0.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
wbs_we_i  in  1  write enable
wbs_cyc_i  in  1  bus cycle valid
wbs_stb_i  in  1  strobe
wbs_adr_i  in  32  word address
wbs_dat_i  in  DATA_WIDTH  write data
wbs_dat_o  out  DATA_WIDTH  read data (registered)
wbs_ack_o  out  1  acknowledge (registered)
wbs_int_o  out  1  interrupt request (registered)
regs_o  out  NUM_REGS*DATA_WIDTH  flattened control registers; reg k is at bits [k*DATA_WIDTH +: DATA_WIDTH]
event_i  in  NUM_EVENTS  user event lines, level; rising edge sets the status bit
status_i  in  DATA_WIDTH  user read-only status word

Behaviour:
- Reset state:
  - wbs_dat_o=0, wbs_ack_o=0, wbs_int_o=0.
  - All control registers 0; INT_EN=0; INT_STAT=0; event delay register=0.
  - FSM in IDLE.
- Register map, with offset = wbs_adr_i - BASE_ADDR (32-bit unsigned, wraps):
  - 0..NUM_REGS-1: CTRL[k], read/write.
  - NUM_REGS: INT_EN, read/write. Only the low NUM_EVENTS bits are stored; upper bits read 0.
  - NUM_REGS+1: INT_STAT. Reads return the sticky bits. A write clears every bit written as 1 (W1C).
  - NUM_REGS+2: STATUS, read-only, returns status_i sampled at the access cycle. Writes are ignored.
  - Any other offset is unmapped: reads return 0, writes have no effect, and the access is still acked.
- FSM, two states:
  - IDLE: when stb&cyc are both 1, perform the access on that edge and go to ACK.
    - Write: update the target register.
    - Read: load wbs_dat_o.
    - Set wbs_ack_o=1.
  - ACK: hold wbs_ack_o=1 and wbs_dat_o stable while wbs_stb_i=1. When wbs_stb_i=0, clear wbs_ack_o and go to IDLE.
  - Exactly one register side effect per strobe. The earliest next access is the cycle after ack drops.
- Latency:
  - ack is visible one cycle after stb/cyc are sampled high.
  - A write is visible on regs_o in the same cycle ack rises.
- Event capture:
  - rise[i] = event_i[i] & ~event_d[i], where event_d is registered every cycle.
  - INT_STAT[i] <= (INT_STAT[i] & ~w1c[i]) | rise[i]. When a rising edge and a W1C of the same bit coincide, set wins.
  - A level that stays high does not re-set a bit after it is cleared.
- Interrupt output: wbs_int_o <= |(INT_STAT & INT_EN), one cycle after either operand changes. Writing INT_EN=0 deasserts the interrupt without losing status.
- cyc dropped while in ACK: treat it as stb low (ack clears, return to IDLE). No access is aborted, because the side effect has already happened.
- rst in any state: returns to the reset values on the next edge, including mid-handshake (ack drops).
- Width rules:
  - wbs_dat_i is used in full for CTRL.
  - Writes to INT_EN and INT_STAT use only bits [NUM_EVENTS-1:0].

Test Plan:
1. Reset, then write 32'hDEADBEEF to BASE_ADDR+2 (NUM_REGS=4) -> ack rises 1 cycle later and stays high until stb drops; regs_o[95:64]=32'hDEADBEEF; read of offset 2 returns 32'hDEADBEEF; other CTRL registers are 0.
2. Read offset 6 with status_i=32'h12345678 -> wbs_dat_o=32'h12345678 with ack. Write 32'hFFFFFFFF to offset 6, then read -> status_i value unchanged.
3. Write INT_EN=4'b0101, pulse event_i[0] and event_i[1] -> INT_STAT=4'b0011; wbs_int_o=1 one cycle after the event_i[0] capture. Write 4'b0001 to INT_STAT -> INT_STAT=4'b0010; wbs_int_o=0 next cycle.
4. Raise event_i[2] on the same edge as a W1C of bit 2 -> INT_STAT[2]=1. Hold event_i[2] high, then clear again -> INT_STAT[2]=0 and stays 0.
5. Read offset 9 (unmapped) and write 32'hAAAA5555 to it -> both acked; read data is 0; no register changes.
6. Assert rst while ack=1 with stb held -> next edge: ack=0, regs_o=0, INT_EN=0, wbs_int_o=0. After rst drops, the held stb is treated as a new access and acked.
